// File: rtl/aecho_indication_drain.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : aecho_indication_drain                                       |
// | Brief   : Drains the aecho echo-request FIFO into a one-entry hold     |
// |           register and delivers each word on the heard indication    |
// |           with a sequence tag, optional pacing gap and a counter of    |
// |           delivered messages.                                          |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module aecho_indication_drain #(
  parameter int WIDTH = 32,
  parameter int SEQW  = 16,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] fifo_first,
  input  logic             fifo_first__RDY,
  input  logic             fifo_deq__RDY,
  output logic             fifo_deq__ENA,
  input  logic             heard__RDY,
  output logic             heard__ENA,
  output logic [WIDTH-1:0] heard_v,
  output logic [SEQW-1:0]  heard_seq,
  output logic [SEQW-1:0]  delivered,
  output logic             busy
);

  // Gap counter is at least one bit wide so GAP=0 still yields a legal vector.
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  localparam logic [GW-1:0]   c_gap_load = GW'(GAP);
  localparam logic [GW-1:0]   c_gap_one  = GW'(1);
  localparam logic [SEQW-1:0] c_seq_one  = SEQW'(1);

  logic             r_hold_valid;
  logic [WIDTH-1:0] r_hold_data;
  logic [SEQW-1:0]  r_seq;
  logic [GW-1:0]    r_gap_cnt;
  logic [SEQW-1:0]  r_delivered;

  logic w_gap_idle;
  logic w_fire_out;
  logic w_deq;

  // Delivery only when holding a word, the pacing gap has expired and the
  // sink is ready; a dequeue may refill in the same cycle the word leaves.
  assign w_gap_idle = (r_gap_cnt == '0);
  assign w_fire_out = nRST & r_hold_valid & w_gap_idle & heard__RDY;
  assign w_deq      = nRST & fifo_first__RDY & fifo_deq__RDY &
                      (~r_hold_valid | w_fire_out);

  assign heard__ENA    = w_fire_out;
  assign fifo_deq__ENA = w_deq;
  assign heard_v       = r_hold_data;
  assign heard_seq     = r_seq;
  assign delivered     = r_delivered;
  assign busy          = r_hold_valid | ~w_gap_idle;

  // Hold register, sequence tag, pacing gap and delivery counter updates.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_seq        <= '0;
      r_gap_cnt    <= '0;
      r_delivered  <= '0;
    end else begin
      if (w_deq) begin
        r_hold_data  <= fifo_first;
        r_hold_valid <= 1'b1;
      end else if (w_fire_out) begin
        r_hold_valid <= 1'b0;
      end

      if (w_fire_out) begin
        r_seq       <= r_seq + c_seq_one;
        r_delivered <= r_delivered + c_seq_one;
        r_gap_cnt   <= c_gap_load;
      end else if (!w_gap_idle) begin
        r_gap_cnt   <= r_gap_cnt - c_gap_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aecho_indication_drain.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_aecho_indication_drain                                    |
// | Brief   : Directed self-checking bench for aecho_indication_drain,     |
// |           covering GAP=0, GAP=2 and SEQW=4 instances.                  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_aecho_indication_drain;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] fifo_first;
  logic        fifo_first__RDY;
  logic        fifo_deq__RDY;
  logic        heard__RDY;

  // Default instance: WIDTH=32, SEQW=16, GAP=0
  logic        d_deq, d_ena, d_busy;
  logic [31:0] d_v;
  logic [15:0] d_seq, d_del;

  // Paced instance: GAP=2
  logic        g_deq, g_ena, g_busy;
  logic [31:0] g_v;
  logic [15:0] g_seq, g_del;

  // Narrow-tag instance: SEQW=4
  logic        w_deq, w_ena, w_busy;
  logic [31:0] w_v;
  logic [3:0]  w_seq, w_del;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  aecho_indication_drain u_dut (
    .CLK(CLK), .nRST(nRST), .fifo_first(fifo_first),
    .fifo_first__RDY(fifo_first__RDY), .fifo_deq__RDY(fifo_deq__RDY),
    .fifo_deq__ENA(d_deq), .heard__RDY(heard__RDY), .heard__ENA(d_ena),
    .heard_v(d_v), .heard_seq(d_seq), .delivered(d_del), .busy(d_busy)
  );

  aecho_indication_drain #(.WIDTH(32), .SEQW(16), .GAP(2)) u_gap (
    .CLK(CLK), .nRST(nRST), .fifo_first(fifo_first),
    .fifo_first__RDY(fifo_first__RDY), .fifo_deq__RDY(fifo_deq__RDY),
    .fifo_deq__ENA(g_deq), .heard__RDY(heard__RDY), .heard__ENA(g_ena),
    .heard_v(g_v), .heard_seq(g_seq), .delivered(g_del), .busy(g_busy)
  );

  aecho_indication_drain #(.WIDTH(32), .SEQW(4), .GAP(0)) u_wrap (
    .CLK(CLK), .nRST(nRST), .fifo_first(fifo_first),
    .fifo_first__RDY(fifo_first__RDY), .fifo_deq__RDY(fifo_deq__RDY),
    .fifo_deq__ENA(w_deq), .heard__RDY(heard__RDY), .heard__ENA(w_ena),
    .heard_v(w_v), .heard_seq(w_seq), .delivered(w_del), .busy(w_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] words [4];
    int k;
    words[0] = 32'hA0; words[1] = 32'hA1; words[2] = 32'hA2; words[3] = 32'hA3;

    // ---------------- Reset with FIFO active ----------------
    nRST = 1'b0; fifo_first = 32'h99; fifo_first__RDY = 1'b1;
    fifo_deq__RDY = 1'b1; heard__RDY = 1'b1;
    tick(); tick();
    @(negedge CLK);
    chk("rst_deq",   d_deq,  0);
    chk("rst_ena",   d_ena,  0);
    chk("rst_v",     d_v,    0);
    chk("rst_seq",   d_seq,  0);
    chk("rst_del",   d_del,  0);
    chk("rst_busy",  d_busy, 0);
    tick();

    // ---------------- Back-to-back 0x11/0x22/0x33 ----------------
    nRST = 1'b1; fifo_first = 32'h11;
    @(negedge CLK);
    chk("b2b_deq0", d_deq, 1);
    chk("b2b_ena0", d_ena, 0);
    tick();
    fifo_first = 32'h22;
    @(negedge CLK);
    chk("b2b_ena1", d_ena, 1); chk("b2b_v1", d_v, 32'h11); chk("b2b_seq1", d_seq, 0);
    chk("b2b_deq1", d_deq, 1);
    tick();
    fifo_first = 32'h33;
    @(negedge CLK);
    chk("b2b_ena2", d_ena, 1); chk("b2b_v2", d_v, 32'h22); chk("b2b_seq2", d_seq, 1);
    tick();
    fifo_first__RDY = 1'b0;
    @(negedge CLK);
    chk("b2b_ena3", d_ena, 1); chk("b2b_v3", d_v, 32'h33); chk("b2b_seq3", d_seq, 2);
    chk("b2b_deq3", d_deq, 0);
    tick();
    @(negedge CLK);
    chk("b2b_ena4", d_ena, 0); chk("b2b_del", d_del, 3); chk("b2b_busy", d_busy, 0);
    tick();

    // ---------------- Backpressure ----------------
    fifo_first = 32'hAAAA5555; fifo_first__RDY = 1'b1; heard__RDY = 1'b0;
    @(negedge CLK);
    chk("bp_deq_load", d_deq, 1);
    tick();
    fifo_first = 32'hBBBB0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("bp_v_%0d", i),   d_v,   32'hAAAA5555);
      chk($sformatf("bp_deq_%0d", i), d_deq, 0);
      chk($sformatf("bp_ena_%0d", i), d_ena, 0);
      chk($sformatf("bp_seq_%0d", i), d_seq, 3);
      tick();
    end
    heard__RDY = 1'b1;
    @(negedge CLK);
    chk("bp_rel_ena", d_ena, 1); chk("bp_rel_deq", d_deq, 1);
    chk("bp_rel_v", d_v, 32'hAAAA5555);
    tick();
    fifo_first__RDY = 1'b0; heard__RDY = 1'b0;
    @(negedge CLK);
    chk("bp_next_v", d_v, 32'hBBBB0000); chk("bp_next_ena", d_ena, 0);
    chk("bp_next_seq", d_seq, 4); chk("bp_next_del", d_del, 4);
    tick();

    // ---------------- GAP=2 stream of 4 words ----------------
    do_reset();
    heard__RDY = 1'b1; k = 0;
    for (int c = 0; c < 14; c++) begin
      fifo_first      = (k < 4) ? words[k] : 32'h0;
      fifo_first__RDY = (k < 4);
      @(negedge CLK);
      chk($sformatf("gap_ena_c%0d", c), g_ena,
          (c == 1 || c == 4 || c == 7 || c == 10) ? 64'd1 : 64'd0);
      chk($sformatf("gap_deq_c%0d", c), g_deq,
          (c == 0 || c == 1 || c == 4 || c == 7) ? 64'd1 : 64'd0);
      chk($sformatf("gap_busy_c%0d", c), g_busy,
          (c >= 1 && c <= 12) ? 64'd1 : 64'd0);
      if (c == 1 || c == 4 || c == 7 || c == 10)
        chk($sformatf("gap_v_c%0d", c), g_v, words[(c - 1) / 3]);
      if (g_deq) k++;
      tick();
    end
    chk("gap_del_end", g_del, 4);

    // ---------------- Empty FIFO with garbage ----------------
    do_reset();
    fifo_first__RDY = 1'b0; heard__RDY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fifo_first = $urandom;
      @(negedge CLK);
      chk($sformatf("empty_deq_%0d", i),  d_deq,  0);
      chk($sformatf("empty_ena_%0d", i),  d_ena,  0);
      chk($sformatf("empty_busy_%0d", i), d_busy, 0);
      tick();
    end

    // ---------------- SEQW=4 wrap, 17 words ----------------
    do_reset();
    heard__RDY = 1'b1; k = 0;
    for (int c = 0; c < 19; c++) begin
      fifo_first      = 32'(k) + 32'h100;
      fifo_first__RDY = (k < 17);
      @(negedge CLK);
      chk($sformatf("wrap_ena_c%0d", c), w_ena, (c >= 1 && c <= 17) ? 64'd1 : 64'd0);
      chk($sformatf("wrap_del_c%0d", c), w_del, (c == 0) ? 64'd0 : 64'((c - 1) % 16));
      if (c >= 1 && c <= 17) begin
        chk($sformatf("wrap_seq_c%0d", c), w_seq, 64'((c - 1) % 16));
        chk($sformatf("wrap_v_c%0d", c),   w_v,   64'(c - 1 + 256));
      end
      if (w_deq) k++;
      tick();
    end
    chk("wrap_del_end", w_del, 1);

    // ---------------- Reset mid-operation ----------------
    do_reset();
    fifo_first = 32'h55; fifo_first__RDY = 1'b1; heard__RDY = 1'b0;
    @(negedge CLK);
    chk("mid_deq", d_deq, 1);
    tick();
    fifo_first__RDY = 1'b0;
    @(negedge CLK);
    chk("mid_held_v", d_v, 32'h55); chk("mid_held_busy", d_busy, 1);
    chk("mid_held_ena", d_ena, 0);
    tick();
    nRST = 1'b0; heard__RDY = 1'b1; fifo_first__RDY = 1'b1; fifo_first = 32'h77;
    @(negedge CLK);
    chk("mid_rst_ena", d_ena, 0); chk("mid_rst_deq", d_deq, 0);
    tick();
    nRST = 1'b1; fifo_first__RDY = 1'b0;
    @(negedge CLK);
    chk("mid_post_busy", d_busy, 0); chk("mid_post_ena", d_ena, 0);
    chk("mid_post_v", d_v, 0);
    tick();
    fifo_first = 32'h66; fifo_first__RDY = 1'b1;
    @(negedge CLK);
    chk("mid_new_deq", d_deq, 1);
    tick();
    fifo_first__RDY = 1'b0;
    @(negedge CLK);
    chk("mid_new_ena", d_ena, 1); chk("mid_new_v", d_v, 32'h66);
    chk("mid_new_seq", d_seq, 0);
    tick();
    @(negedge CLK);
    chk("mid_new_del", d_del, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
